multi_pop_fifo: RTL

MULTI_POP_FIFO -- requirements
Module: multi_pop_fifo

---
 rtl/multi_pop_fifo.sv | 102 ++++++++++
 1 files changed

// File: rtl/multi_pop_fifo.sv
// ============================================================================
// Module   : multi_pop_fifo
// Summary  : Circular-buffer FIFO with single push and up to WIDTH pops/cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multi_pop_fifo #(
  parameter int DEPTH      = 16,
  parameter int WIDTH      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          push_valid,
  input  logic [DATA_WIDTH-1:0]         push_data,
  output logic                          push_ready,
  output logic [DATA_WIDTH-1:0]         data_out [0:WIDTH-1],
  output logic [WIDTH-1:0]              data_out_valid,
  input  logic [$clog2(WIDTH):0]        pop_count,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          full,
  output logic                          empty,
  output logic                          pop_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(WIDTH) + 1;
  localparam int MW = (CW > PW) ? CW : PW;

  localparam logic [MW-1:0] c_width = MW'(WIDTH);
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [AW-1:0]         r_rptr;
  logic [AW-1:0]         r_wptr;
  logic [CW-1:0]         r_count;
  logic                  r_pop_err;

  logic [MW-1:0]         w_avail;
  logic [MW-1:0]         w_pop_req;
  logic [MW-1:0]         w_ep;
  logic                  w_overrun;
  logic                  w_full;
  logic                  w_push;

  // Entries visible in the read window this cycle: min(count, WIDTH).
  assign w_avail   = (MW'(r_count) < c_width) ? MW'(r_count) : c_width;
  assign w_pop_req = MW'(pop_count);
  assign w_overrun = (w_pop_req > w_avail);
  assign w_ep      = w_overrun ? w_avail : w_pop_req;

  assign w_full = (r_count == c_depth);
  assign w_push = push_valid && !w_full && !flush;

  assign full       = w_full;
  assign empty      = (r_count == '0);
  assign push_ready = !w_full;
  assign count      = r_count;
  assign pop_err    = r_pop_err;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_out
      localparam logic [MW-1:0] c_idx = MW'(i);
      logic [AW-1:0] w_idx;
      assign w_idx             = r_rptr + AW'(i);
      assign data_out[i]       = r_mem[w_idx];
      assign data_out_valid[i] = (c_idx < w_avail);
    end
  endgenerate

  // Storage is deliberately left unreset; occupancy alone qualifies the data.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rptr    <= '0;
      r_wptr    <= '0;
      r_count   <= '0;
      r_pop_err <= 1'b0;
    end else if (flush) begin
      r_rptr    <= '0;
      r_wptr    <= '0;
      r_count   <= '0;
      r_pop_err <= 1'b0;
    end else begin
      r_rptr    <= r_rptr + w_ep[AW-1:0];
      r_wptr    <= r_wptr + AW'(w_push);
      r_count   <= r_count + CW'(w_push) - CW'(w_ep);
      r_pop_err <= w_overrun;
    end
  end

endmodule

`default_nettype wire
